// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
//   ADDR_W       : memory address width
//   CNT_W        : wait-counter width
//   MAX_WAIT_DEF : default cycles an access may wait for mem_done
//   arb_state_e  : arbiter FSM state encoding
//   last_grant_e : which requester was granted most recently
package mem_arb_pkg;

   localparam int unsigned ADDR_W       = 16;
   localparam int unsigned CNT_W        = 4;
   localparam int unsigned MAX_WAIT_DEF = 15;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_INST = 2'd2,
      ST_HALT = 2'd3
   } arb_state_e;

   typedef enum logic {
      LG_INST = 1'b0,
      LG_DATA = 1'b1
   } last_grant_e;

endpackage

// File: rtl/wait_timer.sv
// Access watchdog: counts cycles an access spends waiting for mem_done.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : return count to zero (priority over enable)
//   enable   : count one more waiting cycle
//   expired  : count has reached MAX_WAIT
module wait_timer
   import mem_arb_pkg::*;
#(
   parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   assign expired = (count_q == CNT_W'(MAX_WAIT));

   // Saturate at MAX_WAIT so the counter never wraps past the limit.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && !expired) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-port memory between the MEM-stage data port and the
// IF-stage fetch port, and generates the pipeline stalls.
//   clk, rst                         : clock, asynchronous active-high reset
//   data_rd, data_wr, data_addr      : MEM-stage load/store request
//   inst_req, inst_addr              : IF-stage fetch request
//   halt                             : stop issuing new accesses
//   mem_done                         : memory completion strobe
//   mem_en, mem_wr, mem_addr         : memory access start / write / address
//   data_grant, inst_grant           : completion pulses, same cycle as mem_done
//   stall_pipe, stall_fetch          : pipeline freeze controls
//   err                              : sticky error (timeout or rd+wr conflict)
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              data_rd,
   input  logic              data_wr,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic              inst_req,
   input  logic [ADDR_W-1:0] inst_addr,
   input  logic              halt,
   input  logic              mem_done,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              data_grant,
   output logic              inst_grant,
   output logic              stall_pipe,
   output logic              stall_fetch,
   output logic              err
);

   arb_state_e        state_q,    state_d;
   last_grant_e       last_q,     last_d;
   logic              mem_en_q,   mem_en_d;
   logic              mem_wr_q,   mem_wr_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              err_q,      err_d;

   logic data_req;
   logic timer_clear;
   logic timer_en;
   logic timer_expired;
   logic data_grant_w;
   logic inst_grant_w;

   assign data_req = data_rd | data_wr;

   wait_timer #(
      .MAX_WAIT (MAX_WAIT)
   ) u_wait_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (timer_clear),
      .enable  (timer_en),
      .expired (timer_expired)
   );

   // Next-state, access launch and completion logic.
   always_comb begin
      state_d      = state_q;
      last_d       = last_q;
      mem_en_d     = 1'b0;
      mem_wr_d     = mem_wr_q;
      mem_addr_d   = mem_addr_q;
      err_d        = err_q;
      timer_clear  = 1'b1;
      timer_en     = 1'b0;
      data_grant_w = 1'b0;
      inst_grant_w = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (halt) begin
               state_d = ST_HALT;
            end else if (data_rd && data_wr) begin
               // Contradictory MEM-stage command: refuse it and stop.
               err_d   = 1'b1;
               state_d = ST_HALT;
            end else if (data_req && (!inst_req || last_q == LG_INST)) begin
               state_d    = ST_DATA;
               last_d     = LG_DATA;
               mem_en_d   = 1'b1;
               mem_wr_d   = data_wr;
               mem_addr_d = data_addr;
            end else if (inst_req) begin
               state_d    = ST_INST;
               last_d     = LG_INST;
               mem_en_d   = 1'b1;
               mem_wr_d   = 1'b0;
               mem_addr_d = inst_addr;
            end
         end

         ST_DATA, ST_INST: begin
            timer_clear = 1'b0;
            if (timer_expired) begin
               // Timeout wins even over a coincident mem_done.
               err_d       = 1'b1;
               state_d     = ST_HALT;
               timer_clear = 1'b1;
            end else if (mem_done) begin
               data_grant_w = (state_q == ST_DATA);
               inst_grant_w = (state_q == ST_INST);
               state_d      = halt ? ST_HALT : ST_IDLE;
               timer_clear  = 1'b1;
            end else begin
               timer_en = 1'b1;
            end
         end

         ST_HALT: begin
            state_d = ST_HALT;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         last_q     <= LG_INST;
         mem_en_q   <= 1'b0;
         mem_wr_q   <= 1'b0;
         mem_addr_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         mem_en_q   <= mem_en_d;
         mem_wr_q   <= mem_wr_d;
         mem_addr_q <= mem_addr_d;
         err_q      <= err_d;
      end
   end

   assign mem_en     = mem_en_q;
   assign mem_wr     = mem_wr_q;
   assign mem_addr   = mem_addr_q;
   assign err        = err_q;
   assign data_grant = data_grant_w;
   assign inst_grant = inst_grant_w;

   // Stalls release in the grant cycle so the pipeline advances with the data;
   // reset forces them low so every output is quiet while rst is held.
   assign stall_pipe  = !rst && ((state_q == ST_HALT) || (data_req && !data_grant_w));
   assign stall_fetch = !rst && ((state_q == ST_HALT) || (inst_req && !inst_grant_w)
                                 || (data_req && !data_grant_w));

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MAX_WAIT, 15, max cycles a granted access waits for mem_done before it is declared failed.
REQ-002 Port: clk  in  1  system clock; all state changes on its rising edge.
REQ-003 Port: rst  in  1  reset; asynchronous, active-high.
REQ-004 Port: data_rd  in  1  MEM-stage load request (MemRead from EX/MEM register).
REQ-005 Port: data_wr  in  1  MEM-stage store request (MemWrite from EX/MEM register).
REQ-006 Port: data_addr  in  16  MEM-stage address (ALU result from EX/MEM register).
REQ-007 Port: inst_req  in  1  IF-stage fetch request.
REQ-008 Port: inst_addr  in  16  fetch PC.
REQ-009 Port: halt  in  1  halt from EX/MEM register; stops new grants.
REQ-010 Port: mem_done  in  1  one-cycle completion strobe from the shared single-port memory.
REQ-011 Port: mem_en  out  1  one-cycle access-start strobe to memory.
REQ-012 Port: mem_wr  out  1  write qualifier, valid with mem_en.
REQ-013 Port: mem_addr  out  16  access address, held stable for the whole access.
REQ-014 Port: data_grant  out  1  one-cycle pulse: data access complete.
REQ-015 Port: inst_grant  out  1  one-cycle pulse: fetch complete.
REQ-016 Port: stall_pipe  out  1  freezes EX/MEM and all upstream pipeline registers.
REQ-017 Port: stall_fetch  out  1  freezes PC and IF/ID register.
REQ-018 Port: err  out  1  sticky error flag.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, DATA, INST, HALT.
REQ-020 IDLE: halt=1 -> HALT; else a data request (data_rd or data_wr) -> DATA; else inst_req -> INST; else stay in IDLE.
REQ-021 When data and inst requests are both pending in IDLE, grant alternates on a last-grant bit; a lone request wins immediately.
REQ-022 On entering DATA/INST: mem_en=1 for exactly that first cycle; mem_addr and mem_wr are registered from the winning requester (mem_wr=data_wr for data, 0 for inst).
REQ-023 mem_addr and mem_wr hold until the access completes; mem_en never reasserts within one access.
REQ-024 DATA/INST + mem_done=1 -> matching grant pulses that cycle; next state IDLE; wait counter clears.
REQ-025 Access latency: request seen in IDLE at cycle N -> mem_en at N+1 -> grant at earliest N+1 if mem_done arrives then.
REQ-026 stall_pipe = data request pending AND NOT (state==DATA AND mem_done); stall_fetch = inst_req AND NOT (state==INST AND mem_done), OR stall_pipe=1.
REQ-027 A 4-bit wait counter increments each DATA/INST cycle without mem_done; at count==MAX_WAIT, err sets, no grant pulses, next state HALT.
REQ-028 data_rd and data_wr both 1 in IDLE: no access issued, err sets, next state HALT.
REQ-029 mem_done in IDLE or HALT SHALL be ignored.
REQ-030 HALT is terminal until reset: mem_en=0, grants=0, stall_pipe=stall_fetch=1.
REQ-031 halt asserted during DATA/INST: the access completes normally, then -> HALT instead of IDLE.

Reset
REQ-032 rst=1 SHALL immediately force state IDLE, counter 0, last-grant=inst, mem_en=mem_wr=0, mem_addr=0, grants=0, err=0, regardless of clk.
REQ-033 Reset mid-access abandons the access; a mem_done arriving after reset release in IDLE is ignored.

Structure
REQ-034 State encodings (2-bit) and the MAX_WAIT default SHALL live in shared package mem_arb_pkg.
REQ-035 The wait counter SHALL be the sub-module wait_timer (clear, enable, expired output); all other logic is in mem_arbiter.

Verification
REQ-036 data_rd=1, data_addr=0x1234, mem_done 3 cycles after mem_en -> one mem_en with mem_addr=0x1234, mem_wr=0, stall_pipe high 3 cycles, one data_grant.
REQ-037 data_wr=1 and inst_req=1 held, last-grant=inst -> data served first (mem_wr=1), then inst; grants alternate on repeat.
REQ-038 inst_req=1, mem_done never arrives, MAX_WAIT=15 -> err=1 after 15 wait cycles, state HALT, no inst_grant.
REQ-039 data_rd=data_wr=1 in IDLE -> no mem_en, err=1, HALT.
REQ-040 rst pulsed mid-DATA between clock edges -> all outputs 0 immediately; late mem_done produces no grant.
